// File: rtl/align_pkg.sv
// Types shared by the alignment result tracker and the PE array:
// tracker FSM states, traceback direction codes and an index-width helper.
package align_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } align_state_e;

  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_DIAG = 2'd1;
  localparam logic [1:0] DIR_UP   = 2'd2;
  localparam logic [1:0] DIR_LEFT = 2'd3;

  // Width of an index over n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/align_max_tracker_if.sv
// Per-PE score/direction/valid stream leaving the systolic alignment array.
interface align_max_tracker_if #(
  parameter int N       = 5,
  parameter int SCORE_W = 8
);

  logic signed [SCORE_W-1:0] pe_score [N];
  logic        [1:0]         pe_dir   [N];
  logic        [N-1:0]       pe_valid;

  modport master (output pe_score, output pe_dir, output pe_valid);
  modport slave  (input  pe_score, input  pe_dir, input  pe_valid);

endinterface

// File: rtl/align_max_reduce.sv
// Combinational argmax over N candidate cells; on equal scores the lowest
// row index wins.
module align_max_reduce
  import align_pkg::*;
#(
  parameter int N       = 5,
  parameter int SCORE_W = 8,
  parameter int LEN_W   = 8,
  parameter int ROW_W   = idx_w(N)
) (
  input  logic signed [SCORE_W-1:0] score [N],
  input  logic        [LEN_W-1:0]   col   [N],
  input  logic        [1:0]         dir   [N],
  input  logic        [N-1:0]       vld,
  output logic signed [SCORE_W-1:0] max_score,
  output logic        [ROW_W-1:0]   max_row,
  output logic        [LEN_W-1:0]   max_col,
  output logic        [1:0]         max_dir,
  output logic                      max_vld
);

  always_comb begin
    max_score = '0;
    max_row   = '0;
    max_col   = '0;
    max_dir   = DIR_NONE;
    max_vld   = 1'b0;
    for (int i = 0; i < N; i++) begin
      // Strictly-greater replaces, so a later row never displaces an equal earlier one.
      if (vld[i] && (!max_vld || (score[i] > max_score))) begin
        max_score = score[i];
        max_row   = ROW_W'(i);
        max_col   = col[i];
        max_dir   = dir[i];
        max_vld   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/align_max_tracker.sv
// Tracks the best local-alignment score, its (row, column) and direction code
// over one alignment run, and frames the run with an IDLE/RUN/DRAIN/DONE FSM.
module align_max_tracker
  import align_pkg::*;
#(
  parameter int N       = 5,
  parameter int SCORE_W = 8,
  parameter int LEN_W   = 8,
  parameter int ROW_W   = idx_w(N)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear_en,
  input  logic                      start,
  input  logic        [LEN_W-1:0]   ref_len,
  align_max_tracker_if.slave        pe,
  output logic signed [SCORE_W-1:0] best_score,
  output logic        [ROW_W-1:0]   best_row,
  output logic        [LEN_W-1:0]   best_col,
  output logic        [1:0]         best_dir,
  output logic                      best_found,
  output logic                      busy,
  output logic                      done
);

  align_state_e state_q, state_d;
  logic [LEN_W-1:0] ref_len_q, ref_len_d;
  logic [LEN_W-1:0] col_cnt_q [N];
  logic [LEN_W-1:0] col_cnt_d [N];

  logic signed [SCORE_W-1:0] cand_score_q, cand_score_d;
  logic [ROW_W-1:0]          cand_row_q,   cand_row_d;
  logic [LEN_W-1:0]          cand_col_q,   cand_col_d;
  logic [1:0]                cand_dir_q,   cand_dir_d;
  logic                      cand_vld_q,   cand_vld_d;

  logic signed [SCORE_W-1:0] best_score_q, best_score_d;
  logic [ROW_W-1:0]          best_row_q,   best_row_d;
  logic [LEN_W-1:0]          best_col_q,   best_col_d;
  logic [1:0]                best_dir_q,   best_dir_d;
  logic                      best_found_q, best_found_d;
  logic                      done_q,       done_d;

  logic [N-1:0]              beat;
  logic                      last_beat;
  logic signed [SCORE_W-1:0] red_score;
  logic [ROW_W-1:0]          red_row;
  logic [LEN_W-1:0]          red_col;
  logic [1:0]                red_dir;
  logic                      red_vld;

  // A beat counts only while running and while its row still owes columns.
  always_comb begin
    beat = '0;
    for (int i = 0; i < N; i++) begin
      beat[i] = (state_q == RUN) && pe.pe_valid[i] && (col_cnt_q[i] < ref_len_q);
    end
  end

  assign last_beat = beat[N-1] &&
                     (({1'b0, col_cnt_q[N-1]} + (LEN_W+1)'(1)) == {1'b0, ref_len_q});

  align_max_reduce #(
    .N       (N),
    .SCORE_W (SCORE_W),
    .LEN_W   (LEN_W),
    .ROW_W   (ROW_W)
  ) u_reduce (
    .score     (pe.pe_score),
    .col       (col_cnt_q),
    .dir       (pe.pe_dir),
    .vld       (beat),
    .max_score (red_score),
    .max_row   (red_row),
    .max_col   (red_col),
    .max_dir   (red_dir),
    .max_vld   (red_vld)
  );

  always_comb begin
    // NOTE: every *_d gets a value before any branch, so no path leaves one unassigned and infers a latch.
    state_d      = state_q;
    ref_len_d    = ref_len_q;
    col_cnt_d    = col_cnt_q;
    cand_score_d = red_score;
    cand_row_d   = red_row;
    cand_col_d   = red_col;
    cand_dir_d   = red_dir;
    cand_vld_d   = red_vld;
    best_score_d = best_score_q;
    best_row_d   = best_row_q;
    best_col_d   = best_col_q;
    best_dir_d   = best_dir_q;
    best_found_d = best_found_q;
    done_d       = 1'b0;

    if (cand_vld_q && (cand_score_q > best_score_q)) begin
      best_score_d = cand_score_q;
      best_row_d   = cand_row_q;
      best_col_d   = cand_col_q;
      best_dir_d   = cand_dir_q;
      best_found_d = 1'b1;
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          ref_len_d    = ref_len;
          col_cnt_d    = '{default: '0};
          best_score_d = '0;
          best_row_d   = '0;
          best_col_d   = '0;
          best_dir_d   = DIR_NONE;
          best_found_d = 1'b0;
          // An empty reference still drains so done keeps its usual latency.
          state_d      = (ref_len == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < N; i++) begin
          if (beat[i]) col_cnt_d[i] = col_cnt_q[i] + LEN_W'(1);
        end
        if (last_beat) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (clear_en) begin
      state_d      = IDLE;
      ref_len_d    = '0;
      col_cnt_d    = '{default: '0};
      cand_score_d = '0;
      cand_row_d   = '0;
      cand_col_d   = '0;
      cand_dir_d   = DIR_NONE;
      cand_vld_d   = 1'b0;
      best_score_d = '0;
      best_row_d   = '0;
      best_col_d   = '0;
      best_dir_d   = DIR_NONE;
      best_found_d = 1'b0;
      done_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ref_len_q    <= '0;
      // NOTE: the per-row counter array is reset like any other state so an aborted run leaves no stale column.
      col_cnt_q    <= '{default: '0};
      cand_score_q <= '0;
      cand_row_q   <= '0;
      cand_col_q   <= '0;
      cand_dir_q   <= DIR_NONE;
      cand_vld_q   <= 1'b0;
      best_score_q <= '0;
      best_row_q   <= '0;
      best_col_q   <= '0;
      best_dir_q   <= DIR_NONE;
      best_found_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking updates keep every register sampling the pre-edge values.
      state_q      <= state_d;
      ref_len_q    <= ref_len_d;
      col_cnt_q    <= col_cnt_d;
      cand_score_q <= cand_score_d;
      cand_row_q   <= cand_row_d;
      cand_col_q   <= cand_col_d;
      cand_dir_q   <= cand_dir_d;
      cand_vld_q   <= cand_vld_d;
      best_score_q <= best_score_d;
      best_row_q   <= best_row_d;
      best_col_q   <= best_col_d;
      best_dir_q   <= best_dir_d;
      best_found_q <= best_found_d;
      done_q       <= done_d;
    end
  end

  assign best_score = best_score_q;
  assign best_row   = best_row_q;
  assign best_col   = best_col_q;
  assign best_dir   = best_dir_q;
  assign best_found = best_found_q;
  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign done       = done_q;

endmodule

// File: tb/tb_align_max_tracker.sv
// Self-checking bench for align_max_tracker: a vector table of single-column
// runs, skewed-stream corner sequences, and random runs against a score-order model.
module tb_align_max_tracker;

  localparam int N       = 5;
  localparam int SCORE_W = 8;
  localparam int LEN_W   = 8;
  localparam int ROW_W   = 3;

  logic                      clk;
  logic                      rst_n;
  logic                      clear_en;
  logic                      start;
  logic        [LEN_W-1:0]   ref_len;
  logic signed [SCORE_W-1:0] best_score;
  logic        [ROW_W-1:0]   best_row;
  logic        [LEN_W-1:0]   best_col;
  logic        [1:0]         best_dir;
  logic                      best_found;
  logic                      busy;
  logic                      done;

  align_max_tracker_if #(.N(N), .SCORE_W(SCORE_W)) pe_if ();

  align_max_tracker #(
    .N       (N),
    .SCORE_W (SCORE_W),
    .LEN_W   (LEN_W),
    .ROW_W   (ROW_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_en   (clear_en),
    .start      (start),
    .ref_len    (ref_len),
    .pe         (pe_if),
    .best_score (best_score),
    .best_row   (best_row),
    .best_col   (best_col),
    .best_dir   (best_dir),
    .best_found (best_found),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Skewed matrix: row r delivers column c at stream cycle r + c.
  int mat_s [N][8];
  int mat_d [N][8];
  int cap_score, cap_row, cap_col, cap_dir, cap_found, cap_busy;

  typedef struct {
    int s [N];
    int exp_score;
    int exp_row;
    int exp_dir;
    int exp_found;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_stream();
    for (int r = 0; r < N; r++) begin
      pe_if.pe_valid[r] = 1'b0;
      pe_if.pe_score[r] = 8'sd100;
      pe_if.pe_dir[r]   = 2'd2;
    end
  endtask

  task automatic set_beat(input int r, input int s, input int d);
    pe_if.pe_valid[r] = 1'b1;
    pe_if.pe_score[r] = SCORE_W'(s);
    pe_if.pe_dir[r]   = 2'(d);
  endtask

  task automatic do_start(input int len);
    start   = 1'b1;
    ref_len = LEN_W'(len);
    tick();
    start   = 1'b0;
  endtask

  // All rows deliver column 0 together in one cycle (ref_len = 1).
  task automatic run_vec(input vec_t v, input string tag);
    do_start(1);
    for (int r = 0; r < N; r++) set_beat(r, v.s[r], (r + 1) % 4);
    tick();
    idle_stream();
    check({tag, "_early_done"}, int'(done), 0);
    tick();
    check({tag, "_done"},  int'(done),       1);
    check({tag, "_score"}, int'(best_score), v.exp_score);
    check({tag, "_row"},   int'(best_row),   v.exp_row);
    check({tag, "_col"},   int'(best_col),   0);
    check({tag, "_dir"},   int'(best_dir),   v.exp_dir);
    check({tag, "_found"}, int'(best_found), v.exp_found);
  endtask

  task automatic run_matrix(input int len, input bit extra, input bit glitch, input string tag);
    int exp_s, exp_r, exp_c, exp_d, exp_f, done_k, done_cnt, col;
    exp_s = 0; exp_r = 0; exp_c = 0; exp_d = 0; exp_f = 0;
    // Model: visit cells in arrival order (cycle, then row); a strictly larger score wins.
    for (int c = 0; c < len + N - 1; c++) begin
      for (int r = 0; r < N; r++) begin
        col = c - r;
        if (col >= 0 && col < len && mat_s[r][col] > exp_s) begin
          exp_s = mat_s[r][col]; exp_r = r; exp_c = col; exp_d = mat_d[r][col]; exp_f = 1;
        end
      end
    end

    do_start(len);
    check({tag, "_busy"}, int'(busy), 1);
    done_k = -1; done_cnt = 0;
    cap_score = 0; cap_row = 0; cap_col = 0; cap_dir = 0; cap_found = 0; cap_busy = 1;
    for (int k = 0; k < len + N + 2; k++) begin
      for (int r = 0; r < N; r++) begin
        col = k - r;
        if (col >= 0 && col < len)                    set_beat(r, mat_s[r][col], mat_d[r][col]);
        else if (extra && col >= len && col < len + 2) set_beat(r, 50, 3);
        else begin
          pe_if.pe_valid[r] = 1'b0;
          pe_if.pe_score[r] = 8'sd100;
        end
      end
      if (glitch && k == 2) begin
        start   = 1'b1;
        ref_len = LEN_W'(1);
      end else begin
        start = 1'b0;
      end
      tick();
      if (done) begin
        done_cnt++;
        done_k    = k;
        cap_score = int'(best_score);
        cap_row   = int'(best_row);
        cap_col   = int'(best_col);
        cap_dir   = int'(best_dir);
        cap_found = int'(best_found);
        cap_busy  = int'(busy);
      end
    end
    start = 1'b0;
    idle_stream();
    check({tag, "_done_count"}, done_cnt,  1);
    check({tag, "_done_cycle"}, done_k,    len + N - 1);
    check({tag, "_score"},      cap_score, exp_s);
    check({tag, "_row"},        cap_row,   exp_r);
    check({tag, "_col"},        cap_col,   exp_c);
    check({tag, "_dir"},        cap_dir,   exp_d);
    check({tag, "_found"},      cap_found, exp_f);
    check({tag, "_busy_at_done"}, cap_busy, 0);
    check({tag, "_hold"},       int'(best_score), exp_s);
  endtask

  task automatic fill_matrix(input int base);
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < 8; c++) begin
        mat_s[r][c] = base;
        mat_d[r][c] = (r + c) % 4;
      end
    end
  endtask

  initial begin
    int dc;
    vecs[0] = '{s: '{3, 7, 12, 5, 1},        exp_score: 12,  exp_row: 2, exp_dir: 3, exp_found: 1};
    vecs[1] = '{s: '{9, 2, 9, 4, 9},         exp_score: 9,   exp_row: 0, exp_dir: 1, exp_found: 1};
    vecs[2] = '{s: '{-1, -5, 0, -128, 0},    exp_score: 0,   exp_row: 0, exp_dir: 0, exp_found: 0};
    vecs[3] = '{s: '{-3, 127, 127, -128, 5}, exp_score: 127, exp_row: 1, exp_dir: 2, exp_found: 1};
    vecs[4] = '{s: '{1, 1, 1, 1, 2},         exp_score: 2,   exp_row: 4, exp_dir: 1, exp_found: 1};
    vecs[5] = '{s: '{-2, 5, -7, 6, -1},      exp_score: 6,   exp_row: 3, exp_dir: 0, exp_found: 1};

    rst_n = 1'b0; clear_en = 1'b0; start = 1'b0; ref_len = '0;
    idle_stream();
    tick(); tick();
    check("rst_score", int'(best_score), 0);
    check("rst_row",   int'(best_row),   0);
    check("rst_col",   int'(best_col),   0);
    check("rst_dir",   int'(best_dir),   0);
    check("rst_found", int'(best_found), 0);
    check("rst_busy",  int'(busy),       0);
    check("rst_done",  int'(done),       0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    fill_matrix(1);
    mat_s[2][1] = 12;
    run_matrix(4, 1'b0, 1'b0, "peak");
    check("peak_row_const", cap_row, 2);
    check("peak_col_const", cap_col, 1);

    fill_matrix(1);
    mat_s[1][2] = 9; mat_s[3][0] = 9; mat_s[4][1] = 9;
    run_matrix(3, 1'b0, 1'b0, "tie");
    check("tie_row_const", cap_row, 1);
    check("tie_col_const", cap_col, 2);

    fill_matrix(-4);
    mat_s[0][0] = 0; mat_s[3][2] = 0; mat_s[4][1] = -128;
    run_matrix(3, 1'b0, 1'b0, "nonpos");

    fill_matrix(2);
    mat_s[3][1] = 8;
    run_matrix(4, 1'b1, 1'b1, "extra_glitch");

    do_start(0);
    check("len0_busy", int'(busy), 1);
    tick();
    check("len0_done",  int'(done),       1);
    check("len0_found", int'(best_found), 0);
    tick();
    check("len0_pulse", int'(done),       0);

    do_start(4);
    idle_stream(); set_beat(0, 7, 1); tick();
    idle_stream(); set_beat(0, 1, 1); set_beat(1, 1, 1); tick();
    check("clr_peak",  int'(best_score), 7);
    idle_stream(); set_beat(0, 20, 1); set_beat(1, 2, 1); set_beat(2, 1, 1); tick();
    clear_en = 1'b1; idle_stream(); tick(); clear_en = 1'b0;
    check("clr_busy",  int'(busy),       0);
    check("clr_score", int'(best_score), 0);
    check("clr_found", int'(best_found), 0);
    check("clr_done",  int'(done),       0);
    tick();
    check("clr_cand_dropped", int'(best_score), 0);
    dc = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done) dc++;
    end
    check("clr_no_done", dc, 0);
    fill_matrix(-1);
    mat_s[4][2] = 5;
    run_matrix(3, 1'b0, 1'b0, "after_clr");

    do_start(4);
    idle_stream(); set_beat(0, 9, 2); tick();
    idle_stream(); tick();
    check("rstmid_peak", int'(best_score), 9);
    rst_n = 1'b0; tick();
    check("rstmid_score", int'(best_score), 0);
    check("rstmid_busy",  int'(busy),       0);
    check("rstmid_found", int'(best_found), 0);
    rst_n = 1'b1; tick();
    check("rstmid_hold",  int'(best_score), 0);

    for (int n = 0; n < 25; n++) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < 8; c++) begin
          mat_s[r][c] = int'($urandom_range(0, 60)) - 25;
          mat_d[r][c] = int'($urandom_range(0, 3));
        end
      end
      run_matrix(int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/align_max_tracker.md
# align_max_tracker

Downstream consumer of the systolic alignment array. Watches the per-PE score/valid stream, gives each valid beat its (row, column) matrix coordinate, and keeps the running maximum local-alignment score with its coordinate and direction code. A small FSM frames each alignment run and raises `done` once the last row has delivered its final column. The traceback/readout logic reads the result from here.

## Interface
Parameters:
- `N`, 5, number of PEs (rows); must match the array
- `SCORE_W`, 8, signed score width
- `LEN_W`, 8, width of reference length and column index
- `ROW_W`, `$clog2(N)` (min 1), row index width

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `clear_en`  in  1  same clear that drives the array; aborts the run and returns to IDLE
- `start`  in  1  begin a run; accepted in IDLE or DONE only
- `ref_len`  in  LEN_W  number of reference bases in the run; sampled on accepted `start`
- `pe_score`  in  signed SCORE_W [N]  per-PE cell score
- `pe_dir`  in  2 [N]  per-PE traceback direction
- `pe_valid`  in  1 [N]  per-PE beat valid
- `best_score`  out  signed SCORE_W  running max; reset 0
- `best_row`  out  ROW_W  row of max; reset 0
- `best_col`  out  LEN_W  column of max; reset 0
- `best_dir`  out  2  dir of max cell; reset 0
- `best_found`  out  1  at least one score > 0 seen this run; reset 0
- `busy`  out  1  high in RUN and DRAIN; reset 0
- `done`  out  1  one-cycle pulse when the result is final; reset 0

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. Reset or `clear_en` → IDLE; clears all counters and best registers and the pipeline valid. Priority: reset > `clear_en` > `start` > stream.
- IDLE/DONE + `start`: latch `ref_len`, zero `col_cnt[0..N-1]`, best registers, `best_found`; go to RUN. If `ref_len`==0, go to DRAIN instead, so `done` follows after the same drain.
- `start` in RUN/DRAIN is ignored.
- RUN: a beat on row i counts only if `pe_valid[i]`=1 and `col_cnt[i]` < `ref_len`. The beat's column is the pre-increment `col_cnt[i]`, and `col_cnt[i]` then increments. Beats past `ref_len` are dropped.
- RUN → DRAIN in the cycle row N-1 delivers column `ref_len`-1. DRAIN → DONE unconditionally after 1 cycle. `done`=1 for that one cycle.
- DONE holds the results stable until the next `start` or `clear_en`. `pe_valid` is ignored outside RUN.
- Stage 1 (argmax): among counted beats this cycle, select the max `pe_score`. On a tie, the lowest row index wins. Register cand {score, row, col, dir, vld}.
- Stage 2 (update): if cand vld and cand score > `best_score` (signed, strict), load all best fields and set `best_found`. Strict compare means the earliest occurrence wins ties across cycles. Scores ≤ 0 never update.
- Signed compare at full SCORE_W; no saturation in this block.

## Timing
- Beat at cycle t → cand visible t+1 → best outputs updated, visible t+2.
- Final row-N-1 beat at cycle t → DRAIN at t+1 → `done`=1 and `busy`=0 at t+2, and the best outputs already include that beat.
- `start` at cycle t → `busy`=1 at t+1; beats are counted from t+1.
- `clear_en` during RUN/DRAIN: IDLE next cycle, no `done`, and the in-flight cand is discarded.
- `rst_n` low mid-run has the same effect as `clear_en`. All outputs return to reset values next cycle.

## Structure
- Package `align_pkg`: `align_state_e` enum (IDLE, RUN, DRAIN, DONE) and the dir encoding constants shared with the PE (`DIR_NONE`, `DIR_DIAG`, `DIR_UP`, `DIR_LEFT`).
- One sub-module: `align_max_reduce`, a parameterized combinational argmax over N (score, row, col, dir, vld), lowest-index tie-break. The FSM, counters and the two register stages live in the top.

## Test plan
- N=5, `ref_len`=4, skewed stream with row i valid at cycles i..i+3, single peak 12 at row 2 col 1 → `best_score`=12, `best_row`=2, `best_col`=1; `done` exactly 2 cycles after row 4's col-3 beat.
- Same-cycle tie: rows 1 and 3 both 9 → `best_row`=1. Later equal 9 at row 4 → no update.
- All scores ≤ 0 → `done` pulses, `best_found`=0, `best_score`=0, `best_row`/`best_col`=0.
- `ref_len`=0 with `start` → `done` 2 cycles later, `best_found`=0.
- `clear_en` mid-run after a peak of 7 → IDLE next cycle, `best_score`=0, no `done`. A fresh run then reports only its own max.
- Extra valid beats beyond `ref_len` carrying score 50 → ignored. `start` pulsed during RUN → ignored, and `col_cnt` is not reset.
